// File: rtl/freq_meter_if.sv
// Bundle of the freq_meter measurement signals.
// The master side drives the signal under test and the measurement request;
// the slave side (the meter) returns status, the latched result and the
// serial frame.
interface freq_meter_if #(
    parameter int GATE_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
);
    logic                  sig_in;
    logic                  start;
    logic [GATE_WIDTH-1:0] gate_len;
    logic                  busy;
    logic [CNT_WIDTH-1:0]  result;
    logic                  result_valid;
    logic                  overflow;
    logic                  ser_out;
    logic                  ser_frame;

    modport master (
        output sig_in, start, gate_len,
        input  busy, result, result_valid, overflow, ser_out, ser_frame
    );

    modport slave (
        input  sig_in, start, gate_len,
        output busy, result, result_valid, overflow, ser_out, ser_frame
    );
endinterface

// File: rtl/freq_meter.sv
// freq_meter: counts rising edges of sig_in over a gate window of gate_len
// clock cycles, latches the (saturating) count into result/overflow, then
// shifts the count out MSB-first on ser_out while ser_frame is high.
//
// Optional build macro FREQ_METER_CONTINUOUS_EN: when defined, the meter
// re-arms straight from the end of the serial frame into a new gate window
// (resampling gate_len; 0 returns to IDLE). When undefined, every
// measurement needs its own start pulse.
module freq_meter #(
    parameter int GATE_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic         clk,
    input  logic         rst,
    freq_meter_if.slave  bus
);

    localparam int BIT_W = $clog2(CNT_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        SHIFT = 2'd2
    } state_t;

    state_t                state;
    logic                  sig_q;
    logic [GATE_WIDTH-1:0] gate_cnt;
    logic [CNT_WIDTH-1:0]  edge_cnt;
    logic                  ovf;
    logic [CNT_WIDTH-1:0]  shreg;
    logic [BIT_W-1:0]      bit_cnt;

    logic                  edge_det;
    logic [CNT_WIDTH-1:0]  cnt_next;
    logic                  ovf_next;

    // Saturating increment: the count sticks at all-ones instead of wrapping.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(
        input logic [CNT_WIDTH-1:0] value,
        input logic                 inc
    );
        if (inc && !(&value))
            return value + CNT_WIDTH'(1);
        return value;
    endfunction

    // True when an increment is requested on an already saturated count.
    function automatic logic sat_hit(
        input logic [CNT_WIDTH-1:0] value,
        input logic                 inc
    );
        return inc & (&value);
    endfunction

    assign edge_det = bus.sig_in & ~sig_q;
    assign cnt_next = sat_inc(edge_cnt, edge_det);
    assign ovf_next = ovf | sat_hit(edge_cnt, edge_det);

    // One-cycle history of sig_in for rising-edge detection, in every state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            sig_q <= 1'b0;
        else
            sig_q <= bus.sig_in;
    end

    // Measurement FSM: IDLE -> COUNT (gate window) -> SHIFT (serial frame).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            gate_cnt         <= '0;
            edge_cnt         <= '0;
            ovf              <= 1'b0;
            shreg            <= '0;
            bit_cnt          <= '0;
            bus.busy         <= 1'b0;
            bus.result       <= '0;
            bus.result_valid <= 1'b0;
            bus.overflow     <= 1'b0;
            bus.ser_out      <= 1'b0;
            bus.ser_frame    <= 1'b0;
        end else begin
            bus.result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && (bus.gate_len != '0)) begin
                        state    <= COUNT;
                        bus.busy <= 1'b1;
                        gate_cnt <= bus.gate_len;
                        edge_cnt <= '0;
                        ovf      <= 1'b0;
                    end
                end

                COUNT: begin
                    edge_cnt <= cnt_next;
                    ovf      <= ovf_next;
                    gate_cnt <= gate_cnt - GATE_WIDTH'(1);
                    if (gate_cnt == GATE_WIDTH'(1)) begin
                        // Last gate cycle: its edge is folded into the latched count.
                        state            <= SHIFT;
                        bus.result       <= cnt_next;
                        bus.overflow     <= ovf_next;
                        bus.result_valid <= 1'b1;
                        bus.ser_out      <= cnt_next[CNT_WIDTH-1];
                        bus.ser_frame    <= 1'b1;
                        shreg            <= cnt_next << 1;
                        bit_cnt          <= BIT_W'(CNT_WIDTH);
                    end
                end

                SHIFT: begin
                    if (bit_cnt == BIT_W'(1)) begin
                        bus.ser_out   <= 1'b0;
                        bus.ser_frame <= 1'b0;
`ifdef FREQ_METER_CONTINUOUS_EN
                        if (bus.gate_len != '0) begin
                            state    <= COUNT;
                            gate_cnt <= bus.gate_len;
                            edge_cnt <= '0;
                            ovf      <= 1'b0;
                        end else begin
                            state    <= IDLE;
                            bus.busy <= 1'b0;
                        end
`else
                        state    <= IDLE;
                        bus.busy <= 1'b0;
`endif
                    end else begin
                        bus.ser_out <= shreg[CNT_WIDTH-1];
                        shreg       <= shreg << 1;
                        bit_cnt     <= bit_cnt - BIT_W'(1);
                    end
                end

                default: begin
                    state         <= IDLE;
                    bus.busy      <= 1'b0;
                    bus.ser_out   <= 1'b0;
                    bus.ser_frame <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/freq_meter.md
Name: freq_meter

Overview:
- Downstream measurement stage for the 1-bit phase-accumulator MSB output.
- Counts rising edges of that bit over a programmable gate window of clock cycles.
- Latches the count, then serialises it MSB-first on a single pin so it fits a one-bit output budget.
- Lets the bench and silicon check the accumulator frequency (f_msb = add_value·f_clk/2^ACC_WIDTH) without a wide bus.

Parameters:
GATE_WIDTH, 16, width of gate_len; the gate window is gate_len cycles (1..2^GATE_WIDTH-1).
CNT_WIDTH, 16, width of the edge counter, result and serial frame length.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous active-high reset
sig_in  input  1  signal under measurement (accumulator MSB), same clock domain
start  input  1  request a measurement; sampled only in IDLE
gate_len  input  GATE_WIDTH  gate window length in cycles; sampled when start is accepted
busy  output  1  high whenever state != IDLE
result  output  CNT_WIDTH  last latched edge count; holds until the next latch
result_valid  output  1  one-cycle pulse when result updates
overflow  output  1  counter saturated during the last measurement; updates with result
ser_out  output  1  serial result bit, MSB first
ser_frame  output  1  high while ser_out carries valid bits

Behaviour:
Reset (async, rst=1) values:
- state=IDLE; result=0, result_valid=0, overflow=0.
- ser_out=0, ser_frame=0, busy=0.
- sig_q=0; internal counters=0.
- Reset mid-measurement aborts immediately with no partial result.

Edge detect:
- sig_q <= sig_in every cycle in every state.
- edge = sig_in & ~sig_q.
- An edge is counted only in a COUNT cycle.

States:
- IDLE: start=1 and gate_len!=0 at cycle T -> COUNT.
  - Load gate counter = gate_len and edge count = 0.
  - start with gate_len==0 is ignored; stay IDLE.
- COUNT: occupies exactly cycles T+1 .. T+gate_len.
  - Each cycle with edge=1: count+1.
  - At all-ones the count saturates and a sticky ovf flag is set.
  - The gate counter decrements each cycle. The last COUNT cycle is where gate counter==1; its edge is included.
  - Then -> SHIFT.
- COUNT->SHIFT transition:
  - result <= final count (including the last-cycle edge); overflow <= ovf.
  - Shift register <= final count; bit counter = CNT_WIDTH.
  - result_valid=1 during the first SHIFT cycle only (cycle T+gate_len+1).
- SHIFT: CNT_WIDTH cycles, T+gate_len+1 .. T+gate_len+CNT_WIDTH.
  - ser_frame=1; ser_out = shift register MSB; shift left with 0 fill each cycle.
  - After the last bit -> IDLE; ser_out returns to 0.
- start while busy=1 is ignored entirely; it is not queued.
- gate_len changes during COUNT have no effect.

Optional Feature:
Macro FREQ_METER_CONTINUOUS_EN.
- Defined: on SHIFT completion the block re-arms straight into COUNT, with no IDLE cycle.
  - gate_len is resampled at that moment. If it is 0, go to IDLE instead.
  - Runs back-to-back until rst or gate_len=0. start is needed only for the first run.
- Undefined: SHIFT always returns to IDLE; each measurement requires its own start.

Test Plan:
1. sig_in period 4 (2 high/2 low), gate_len=40, start pulse at cycle T:
   - result=10, overflow=0.
   - result_valid single pulse at T+41.
   - busy high T+1..T+56; IDLE at T+57.
2. Same run, check the serial frame: ser_frame high exactly 16 cycles from T+41; ser_out = 0000_0000_0000_1010.
3. CNT_WIDTH=4, sig_in period 2, gate_len=64 (32 edges) -> result=15, overflow=1, ser_out=1111 over 4 frame cycles.
4. gate_len=0 with start -> busy stays 0, no result_valid. Then start during COUNT of a gate_len=20 run -> exactly one result_valid, result unchanged by the second start.
5. rst asserted mid-COUNT with sig_in toggling -> all outputs 0 asynchronously. After release, a new start with gate_len=40 (period 4) gives result=10.
6. With FREQ_METER_CONTINUOUS_EN, gate_len=8, period 4:
   - result_valid pulses every 8+16=24 cycles, each result=2.
   - Setting gate_len=0 mid-run -> IDLE after the current frame.
